// File: rtl/dro_bank_scheduler.sv
// dro_bank_scheduler: shares one pulse-issue slot between a write port (set pulse)
// and a read port (reset pulse, then capture of the cell's out toggle) across a
// bank of N_CELL dro cells, keeping a minimum spacing between pulses to any cell.
// Optional feature macro: DRO_SHADOW_CHK_EN builds a shadow copy of the expected
// cell contents and raises a sticky err when a readout disagrees with it.

module dro_bank_scheduler #(
  parameter int N_CELL    = 8,
  parameter int GUARD_CYC = 3,
  parameter int READ_LAT  = 2,
  localparam int AW       = $clog2(N_CELL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic              rd_data,
  output logic [N_CELL-1:0] set_tgl,
  output logic [N_CELL-1:0] reset_tgl,
  input  logic [N_CELL-1:0] dro_out,
  output logic              err
);

  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int WW = $clog2(READ_LAT + 1);
  // The grant cycle itself counts towards the spacing, so the counter is loaded
  // one short: a cell granted on edge k becomes eligible again on edge k+GUARD_CYC.
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);
  localparam logic [WW-1:0] WAIT_LOAD  = WW'(READ_LAT);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t            state;
  logic              rr;
  logic [WW-1:0]     wait_cnt;
  logic [AW-1:0]     rd_cell;
  logic [N_CELL-1:0] out_last;
  logic              primed;
  logic [GW-1:0]     guard_cnt [N_CELL];

  logic wr_ok;
  logic rd_ok;
  logic wr_grant;
  logic rd_grant;
  logic capture;
  logic sample;

  // Eligibility, round-robin arbitration and the readout sample for the latched cell
  always_comb begin
    wr_ok    = 1'b0;
    rd_ok    = 1'b0;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    capture  = 1'b0;
    sample   = 1'b0;
    if (state == IDLE) begin
      wr_ok = wr_req && (int'(wr_addr) < N_CELL) && (guard_cnt[wr_addr] == '0);
      rd_ok = rd_req && (int'(rd_addr) < N_CELL) && (guard_cnt[rd_addr] == '0);
    end
    wr_grant = wr_ok && (!rd_ok || !rr);
    rd_grant = rd_ok && (!wr_ok || rr);
    capture  = (state == RD_WAIT) && (wait_cnt == '0);
    sample   = dro_out[rd_cell] ^ out_last[rd_cell];
  end

  // Main controller: issues pulses, tracks the read wait and drives the registered handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      wait_cnt  <= '0;
      rd_cell   <= '0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 1'b0;
      set_tgl   <= '0;
      reset_tgl <= '0;
    end else begin
      wr_ack   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_grant) begin
            set_tgl[wr_addr] <= ~set_tgl[wr_addr];
            wr_ack           <= 1'b1;
            rr               <= 1'b1;
          end else if (rd_grant) begin
            reset_tgl[rd_addr] <= ~reset_tgl[rd_addr];
            rd_cell            <= rd_addr;
            wait_cnt           <= WAIT_LOAD;
            rr                 <= 1'b0;
            state              <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end else begin
            rd_data  <= sample;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-cell guard counters: reload on any pulse to the cell, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CELL; i++) begin
        guard_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CELL; i++) begin
        if ((wr_grant && (int'(wr_addr) == i)) || (rd_grant && (int'(rd_addr) == i))) begin
          guard_cnt[i] <= GUARD_LOAD;
        end else if (guard_cnt[i] != '0) begin
          guard_cnt[i] <= guard_cnt[i] - GW'(1);
        end
      end
    end
  end

  // Reference level of each out line: primed once after reset, refreshed on every readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last <= '0;
      primed   <= 1'b0;
    end else if (!primed) begin
      out_last <= dro_out;
      primed   <= 1'b1;
    end else if (capture) begin
      out_last[rd_cell] <= dro_out[rd_cell];
    end
  end

`ifdef DRO_SHADOW_CHK_EN
  logic [N_CELL-1:0] shadow;

  // Shadow of expected cell contents; a readout that disagrees sets err until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      err    <= 1'b0;
    end else begin
      if (wr_grant) begin
        shadow[wr_addr] <= 1'b1;
      end
      if (capture) begin
        shadow[rd_cell] <= 1'b0;
        if (sample != shadow[rd_cell]) begin
          err <= 1'b1;
        end
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
